// File: rtl/game_flow_if.sv
// game_flow_if: signals exchanged between game_flow_ctrl and the input debouncers,
// game world logic, game timer and HUD renderer.
interface game_flow_if;
    logic       btn_start;
    logic       btn_pause;
    logic       player_dead;
    logic       all_enemies_dead;
    logic       timer_done;
    logic       timer_start;
    logic       timer_tick;
    logic [2:0] state;
    logic [7:0] ready_cnt;
    logic       game_active;

    // Sequencer side
    modport master (
        input  btn_start, btn_pause, player_dead, all_enemies_dead, timer_done,
        output timer_start, timer_tick, state, ready_cnt, game_active
    );

    // Environment side
    modport slave (
        output btn_start, btn_pause, player_dead, all_enemies_dead, timer_done,
        input  timer_start, timer_tick, state, ready_cnt, game_active
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: READY/PLAY/PAUSE/WIN/LOSE sequencer that drives the game timer's reload
// pulse and gated tick. PAUSE exists only when GAME_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned TICK_HZ     = 60,
    parameter int unsigned READY_TICKS = 180
) (
    input logic         clk,
    input logic         reset,
    game_flow_if.master bus
);
    localparam int unsigned   DIV        = CLK_HZ / TICK_HZ;
    localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [7:0]    READY_LOAD = 8'(READY_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    ready_q, ready_d;
    logic          start_q, start_d;
    logic          tick_q;
    logic          active_q;
    logic          wrap;

    assign wrap = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        start_d = 1'b0;
        presc_d = wrap ? '0 : presc_q + PW'(1);
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.btn_start) begin
                    // Clearing the prescaler here fixes the phase of every later tick.
                    state_d = S_READY;
                    ready_d = READY_LOAD;
                    start_d = 1'b1;
                    presc_d = '0;
                end
            end
            S_READY: begin
                if (wrap) begin
                    ready_d = ready_q - 8'd1;
                    if (ready_q == 8'd1) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (bus.player_dead || bus.timer_done) state_d = S_LOSE;
                else if (bus.all_enemies_dead)         state_d = S_WIN;
`ifdef GAME_PAUSE_EN
                else if (bus.btn_pause)                state_d = S_PAUSE;
`endif
            end
            S_PAUSE: begin
`ifdef GAME_PAUSE_EN
                if (bus.btn_pause) state_d = S_PLAY;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            ready_q  <= '0;
            start_q  <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            // Gated on the current state so a wrap coinciding with an exit still ticks.
            tick_q   <= wrap && (state_q == S_PLAY);
            active_q <= (state_d == S_PLAY);
        end
    end

    assign bus.state       = state_q;
    assign bus.ready_cnt   = ready_q;
    assign bus.timer_start = start_q;
    assign bus.timer_tick  = tick_q;
    assign bus.game_active = active_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed bench for game_flow_ctrl with DIV=10, READY_TICKS=3;
// expected tick cycles are queued as stimulus is applied and matched against observed ticks.
module tb_game_flow_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    game_flow_if bus ();

    game_flow_ctrl #(
        .CLK_HZ(600),
        .TICK_HZ(60),
        .READY_TICKS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int start_cnt = 0;
    int ga_bad    = 0;
    int obs_tick_q[$];
    int exp_tick_q[$];
    int t0, t1, t2, t3;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.timer_tick === 1'b1) obs_tick_q.push_back(cyc);
        if (bus.timer_start === 1'b1) start_cnt++;
        if ((bus.state === 3'd2) != (bus.game_active === 1'b1)) ga_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_ticks(input string tag);
        chk({tag, "_count"}, obs_tick_q.size(), exp_tick_q.size());
        while (obs_tick_q.size() > 0 && exp_tick_q.size() > 0)
            chk(tag, obs_tick_q.pop_front(), exp_tick_q.pop_front());
        obs_tick_q.delete();
        exp_tick_q.delete();
    endtask

    task automatic press_start();
        bus.btn_start = 1'b1;
        @(posedge clk);
        #1;
        bus.btn_start = 1'b0;
    endtask

    task automatic press_pause();
        bus.btn_pause = 1'b1;
        @(posedge clk);
        #1;
        bus.btn_pause = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_start        = 1'b0;
        bus.btn_pause        = 1'b0;
        bus.player_dead      = 1'b0;
        bus.all_enemies_dead = 1'b0;
        bus.timer_done       = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_timer_start", bus.timer_start, 0);
        chk("rst_timer_tick", bus.timer_tick, 0);
        chk("rst_ready_cnt", bus.ready_cnt, 0);
        chk("rst_game_active", bus.game_active, 0);
        wait_cyc(3);
        reset = 1'b0;

        // IDLE -> READY -> PLAY
        wait_cyc(4);
        press_start();
        t0 = cyc;
        chk("start_pulse", bus.timer_start, 1);
        chk("ready_state", bus.state, 1);
        chk("ready_load", bus.ready_cnt, 3);
        @(posedge clk);
        #1;
        chk("start_width", bus.timer_start, 0);
        wait_cyc(t0 + 9);
        chk("ready_hold3", bus.ready_cnt, 3);
        wait_cyc(t0 + 10);
        chk("ready_step2", bus.ready_cnt, 2);
        wait_cyc(t0 + 20);
        chk("ready_step1", bus.ready_cnt, 1);
        wait_cyc(t0 + 29);
        chk("ready_last", bus.state, 1);
        wait_cyc(t0 + 30);
        chk("play_state", bus.state, 2);
        chk("play_ready_cnt", bus.ready_cnt, 0);
        check_ticks("ready_ticks");

        for (int k = 1; k <= 10; k++) exp_tick_q.push_back(t0 + 30 + 10 * k);
        wait_cyc(t0 + 131);
        check_ticks("play_ticks");

        // Pause pressed while the prescaler is at 4, resumed 50 clks later
        wait_cyc(t0 + 134);
        press_pause();
`ifdef GAME_PAUSE_EN
        chk("pause_state", bus.state, 3);
        chk("pause_active", bus.game_active, 0);
`else
        chk("pause_ignored", bus.state, 2);
        for (int k = 1; k <= 5; k++) exp_tick_q.push_back(t0 + 130 + 10 * k);
`endif
        wait_cyc(t0 + 184);
        press_pause();
        chk("resume_state", bus.state, 2);
        exp_tick_q.push_back(t0 + 190);
        wait_cyc(t0 + 191);
        check_ticks("pause_ticks");

        // timer_done -> LOSE, then restart with timer_done still high
        wait_cyc(t0 + 193);
        bus.timer_done = 1'b1;
        @(posedge clk);
        #1;
        chk("lose_timer", bus.state, 5);
        chk("lose_active", bus.game_active, 0);
        wait_cyc(t0 + 220);
        check_ticks("lose_ticks");
        press_start();
        t1 = cyc;
        chk("restart_pulse", bus.timer_start, 1);
        chk("restart_state", bus.state, 1);
        @(posedge clk);
        #1;
        chk("restart_width", bus.timer_start, 0);
        wait_cyc(t1 + 5);
        chk("stale_done", bus.state, 1);
        bus.timer_done = 1'b0;

        // READY ignores pause and events
        wait_cyc(t1 + 10);
        bus.btn_pause   = 1'b1;
        bus.player_dead = 1'b1;
        @(posedge clk);
        #1;
        bus.btn_pause   = 1'b0;
        bus.player_dead = 1'b0;
        chk("ready_ignore", bus.state, 1);
        chk("ready_ignore_cnt", bus.ready_cnt, 2);

        // Both death events on a wrap cycle -> LOSE, wrap tick still emitted
        wait_cyc(t1 + 30);
        chk("replay_state", bus.state, 2);
        exp_tick_q.push_back(t1 + 40);
        wait_cyc(t1 + 39);
        bus.player_dead      = 1'b1;
        bus.all_enemies_dead = 1'b1;
        @(posedge clk);
        #1;
        bus.player_dead      = 1'b0;
        bus.all_enemies_dead = 1'b0;
        chk("lose_both", bus.state, 5);
        chk("exit_tick_now", bus.timer_tick, 1);
        wait_cyc(t1 + 60);
        check_ticks("exit_wrap_tick");

        // Start and pause together from LOSE; then level cleared -> WIN
        bus.btn_pause = 1'b1;
        press_start();
        bus.btn_pause = 1'b0;
        t2 = cyc;
        chk("start_and_pause", bus.state, 1);
        wait_cyc(t2 + 34);
        bus.all_enemies_dead = 1'b1;
        @(posedge clk);
        #1;
        bus.all_enemies_dead = 1'b0;
        chk("win_state", bus.state, 4);
        press_pause();
        chk("win_terminal", bus.state, 4);
        wait_cyc(t2 + 60);
        check_ticks("win_ticks");

        // Reset in PLAY with prescaler at 7
        press_start();
        t3 = cyc;
        wait_cyc(t3 + 37);
        chk("pre_reset", bus.state, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", bus.state, 0);
        chk("mid_rst_tick", bus.timer_tick, 0);
        chk("mid_rst_ready", bus.ready_cnt, 0);
        chk("mid_rst_active", bus.game_active, 0);
        chk("mid_rst_start", bus.timer_start, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cyc(cyc + 30);
        chk("post_rst_state", bus.state, 0);
        check_ticks("reset_ticks");
        chk("start_total", start_cnt, 4);
        chk("game_active_track", ga_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
